stack_mc_cntrl: RTL and testbench

Multi-context LIFO stack with embedded storage: K independent stacks of N entries × W bits behind a single command port. Each accepted command produces exactly one registered response one cycle later, under a valid/ready handshake on both sides. It replaces single-stack pointer controllers wherever several hardware contexts (threads, queues, channels) each need a private stack but share one controller and one set of storage.

---
 rtl/stack_mc_cntrl.sv | 159 +++++++++++++++
 tb/tb_stack_mc_cntrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_mc_cntrl.sv
// Multi-context LIFO: K stacks of N x W entries behind one command port.
// Optional occupancy output o_occ enabled by Q_STACK_MC_CNTRL_OCC_EN.
module stack_mc_cntrl #(
  parameter int N      = 16,
  parameter int W      = 32,
  parameter int K      = 4,
  parameter int ADDR_W = $clog2(N),
  parameter int CTX_W  = $clog2(K),
  parameter int CNT_W  = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             i_cmd_vld,
  input  logic [CTX_W-1:0] i_cmd_ctx,
  input  logic             i_cmd_push,
  input  logic             i_cmd_pop,
  input  logic [W-1:0]     i_cmd_data,
  output logic             o_cmd_rdy,
  output logic             o_rsp_vld,
  input  logic             i_rsp_rdy,
  output logic [CTX_W-1:0] o_rsp_ctx,
  output logic [W-1:0]     o_rsp_data,
  output logic             o_rsp_err,
  output logic [K-1:0]     o_empty,
  output logic [K-1:0]     o_full
`ifdef Q_STACK_MC_CNTRL_OCC_EN
  ,
  output logic [K*CNT_W-1:0] o_occ
`endif
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(N);

  logic [CNT_W-1:0]  cnt_q [K];
  logic [CNT_W-1:0]  cnt_d [K];
  logic [W-1:0]      mem_q [K][N];

  logic              rsp_vld_q, rsp_vld_d;
  logic [CTX_W-1:0]  rsp_ctx_q, rsp_ctx_d;
  logic [W-1:0]      rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;

  logic              acc;
  logic [CNT_W-1:0]  cur;
  logic              has, full;
  logic [ADDR_W-1:0] top_idx;
  logic [W-1:0]      top;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_idx;
  logic [W-1:0]      wr_data;

  logic is_push, is_pop, is_repl, is_peek;

  assign o_cmd_rdy = ~rsp_vld_q | i_rsp_rdy;
  assign acc       = i_cmd_vld & o_cmd_rdy;

  assign is_push = i_cmd_push & ~i_cmd_pop;
  assign is_pop  = ~i_cmd_push & i_cmd_pop;
  assign is_repl = i_cmd_push & i_cmd_pop;
  assign is_peek = ~i_cmd_push & ~i_cmd_pop;

  always_comb begin
    cur     = cnt_q[i_cmd_ctx];
    has     = (cur != '0);
    full    = (cur == CNT_FULL);
    top_idx = ADDR_W'(cur - CNT_ONE);
    top     = mem_q[i_cmd_ctx][top_idx];
  end

  always_comb begin
    cnt_d      = cnt_q;
    rsp_vld_d  = rsp_vld_q & ~i_rsp_rdy;
    rsp_ctx_d  = rsp_ctx_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    wr_en      = 1'b0;
    wr_idx     = top_idx;
    wr_data    = i_cmd_data;
    if (acc) begin
      rsp_vld_d  = 1'b1;
      rsp_ctx_d  = i_cmd_ctx;
      rsp_data_d = '0;
      rsp_err_d  = 1'b0;
      unique case (1'b1)
        is_push: begin
          if (!full) begin
            wr_en            = 1'b1;
            wr_idx           = ADDR_W'(cur);
            cnt_d[i_cmd_ctx] = cur + CNT_ONE;
          end else begin
            rsp_err_d = 1'b1;
          end
        end
        is_pop: begin
          if (has) begin
            rsp_data_d       = top;
            cnt_d[i_cmd_ctx] = cur - CNT_ONE;
          end else begin
            rsp_err_d = 1'b1;
          end
        end
        // Replace on an empty context echoes the data without storing it
        is_repl: begin
          if (has) begin
            rsp_data_d = top;
            wr_en      = 1'b1;
          end else begin
            rsp_data_d = i_cmd_data;
          end
        end
        is_peek: begin
          if (has) rsp_data_d = top;
          else     rsp_err_d  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[i_cmd_ctx][wr_idx] <= wr_data;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int k = 0; k < K; k++) cnt_q[k] <= '0;
      rsp_vld_q  <= 1'b0;
      rsp_ctx_q  <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_ctx_q  <= rsp_ctx_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign o_rsp_vld  = rsp_vld_q;
  assign o_rsp_ctx  = rsp_ctx_q;
  assign o_rsp_data = rsp_data_q;
  assign o_rsp_err  = rsp_err_q;

  always_comb begin
    for (int k = 0; k < K; k++) begin
      o_empty[k] = (cnt_q[k] == '0);
      o_full[k]  = (cnt_q[k] == CNT_FULL);
    end
  end

`ifdef Q_STACK_MC_CNTRL_OCC_EN
  always_comb begin
    for (int k = 0; k < K; k++) o_occ[k*CNT_W +: CNT_W] = cnt_q[k];
  end
`endif

endmodule

// File: tb/tb_stack_mc_cntrl.sv
// Bench for stack_mc_cntrl: queue-based stack model, per-cycle compare,
// directed literal sequences plus randomized traffic.
module tb_stack_mc_cntrl;
  localparam int N = 4;
  localparam int W = 8;
  localparam int K = 2;
  localparam int CTX_W = $clog2(K);
  localparam int CNT_W = $clog2(N + 1);

  logic             clk = 1'b0;
  logic             arst = 1'b0;
  logic             i_cmd_vld = 1'b0;
  logic [CTX_W-1:0] i_cmd_ctx = '0;
  logic             i_cmd_push = 1'b0;
  logic             i_cmd_pop = 1'b0;
  logic [W-1:0]     i_cmd_data = '0;
  logic             o_cmd_rdy;
  logic             o_rsp_vld;
  logic             i_rsp_rdy = 1'b1;
  logic [CTX_W-1:0] o_rsp_ctx;
  logic [W-1:0]     o_rsp_data;
  logic             o_rsp_err;
  logic [K-1:0]     o_empty;
  logic [K-1:0]     o_full;
`ifdef Q_STACK_MC_CNTRL_OCC_EN
  logic [K*CNT_W-1:0] o_occ;
`endif

  int checks = 0;
  int errors = 0;

  stack_mc_cntrl #(.N(N), .W(W), .K(K)) dut (
    .clk        (clk),
    .arst       (arst),
    .i_cmd_vld  (i_cmd_vld),
    .i_cmd_ctx  (i_cmd_ctx),
    .i_cmd_push (i_cmd_push),
    .i_cmd_pop  (i_cmd_pop),
    .i_cmd_data (i_cmd_data),
    .o_cmd_rdy  (o_cmd_rdy),
    .o_rsp_vld  (o_rsp_vld),
    .i_rsp_rdy  (i_rsp_rdy),
    .o_rsp_ctx  (o_rsp_ctx),
    .o_rsp_data (o_rsp_data),
    .o_rsp_err  (o_rsp_err),
    .o_empty    (o_empty),
    .o_full     (o_full)
`ifdef Q_STACK_MC_CNTRL_OCC_EN
    ,
    .o_occ      (o_occ)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // Reference: one queue per context, back of queue is top of stack
  logic [W-1:0]     stk [K][$];
  logic             m_vld = 1'b0;
  logic [CTX_W-1:0] m_ctx = '0;
  logic [W-1:0]     m_data = '0;
  logic             m_err = 1'b0;

  always @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int k = 0; k < K; k++) stk[k].delete();
      m_vld = 1'b0; m_ctx = '0; m_data = '0; m_err = 1'b0;
    end else if (i_cmd_vld && (!m_vld || i_rsp_rdy)) begin
      int c;
      int sz;
      c = int'(i_cmd_ctx);
      sz = stk[c].size();
      m_vld = 1'b1; m_ctx = i_cmd_ctx; m_data = '0; m_err = 1'b0;
      case ({i_cmd_push, i_cmd_pop})
        2'b10: if (sz < N) stk[c].push_back(i_cmd_data); else m_err = 1'b1;
        2'b01: if (sz > 0) m_data = stk[c].pop_back(); else m_err = 1'b1;
        2'b11: begin
          if (sz > 0) begin
            m_data = stk[c][sz-1];
            stk[c][sz-1] = i_cmd_data;
          end else begin
            m_data = i_cmd_data;
          end
        end
        default: if (sz > 0) m_data = stk[c][sz-1]; else m_err = 1'b1;
      endcase
    end else if (i_rsp_rdy) begin
      m_vld = 1'b0;
    end
  end

  always @(negedge clk) begin
    logic [K-1:0] e_empty, e_full;
    for (int k = 0; k < K; k++) begin
      e_empty[k] = (stk[k].size() == 0);
      e_full[k]  = (stk[k].size() == N);
`ifdef Q_STACK_MC_CNTRL_OCC_EN
      chk("m_occ", 32'(o_occ[k*CNT_W +: CNT_W]), 32'(stk[k].size()));
`endif
    end
    chk("m_rsp_vld", 32'(o_rsp_vld), 32'(m_vld));
    if (m_vld) begin
      chk("m_rsp_ctx", 32'(o_rsp_ctx), 32'(m_ctx));
      chk("m_rsp_data", 32'(o_rsp_data), 32'(m_data));
      chk("m_rsp_err", 32'(o_rsp_err), 32'(m_err));
    end
    chk("m_empty", 32'(o_empty), 32'(e_empty));
    chk("m_full", 32'(o_full), 32'(e_full));
    chk("m_cmd_rdy", 32'(o_cmd_rdy), 32'(!m_vld || i_rsp_rdy));
  end

  // Called at posedge+1; returns the registered response of this command
  task automatic cmd(input int c, input bit pu, input bit po,
                     input logic [W-1:0] d,
                     output logic [W-1:0] rd, output logic er);
    int n = 0;
    i_cmd_vld = 1'b1; i_cmd_ctx = CTX_W'(c);
    i_cmd_push = pu; i_cmd_pop = po; i_cmd_data = d;
    while (!o_cmd_rdy && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 20) chk("cmd_accept_timeout", 32'(n), 32'(0));
    @(posedge clk); #1;
    i_cmd_vld = 1'b0;
    rd = o_rsp_data; er = o_rsp_err;
  endtask

  task automatic rnd_drive();
    int r;
    r = $urandom_range(0, 9);
    i_cmd_vld  = ($urandom_range(0, 4) != 0);
    i_cmd_ctx  = CTX_W'($urandom_range(0, K - 1));
    i_cmd_push = (r <= 3) || (r == 7);
    i_cmd_pop  = (r >= 4 && r <= 7);
    i_cmd_data = W'($urandom);
    i_rsp_rdy  = ($urandom_range(0, 3) != 0);
  endtask

  initial begin
    logic [W-1:0] rd;
    logic er;
    #2 arst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1 arst = 1'b0;
    @(posedge clk); #1;
    repeat (2) begin @(posedge clk); #1; end
    chk("rst_empty", 32'(o_empty), 32'h3);
    chk("rst_full", 32'(o_full), 32'h0);
    chk("rst_vld", 32'(o_rsp_vld), 32'h0);

    cmd(0, 1, 0, 8'h11, rd, er);
    chk("push1_err", 32'(er), 32'h0);
    chk("push1_data", 32'(rd), 32'h0);
    cmd(0, 1, 0, 8'h22, rd, er);
    cmd(0, 1, 0, 8'h33, rd, er);
    cmd(0, 1, 0, 8'h44, rd, er);
    chk("full_after4", 32'(o_full), 32'h1);
    cmd(0, 1, 0, 8'h55, rd, er);
    chk("ovf_err", 32'(er), 32'h1);
    chk("ovf_data", 32'(rd), 32'h0);
    cmd(0, 0, 1, 8'h00, rd, er);
    chk("pop_after_ovf", 32'(rd), 32'h44);
    chk("pop_after_ovf_err", 32'(er), 32'h0);

    cmd(1, 0, 1, 8'h00, rd, er);
    chk("unf_err", 32'(er), 32'h1);
    chk("unf_data", 32'(rd), 32'h0);
    chk("unf_empty", 32'(o_empty), 32'h2);
    cmd(1, 0, 0, 8'h00, rd, er);
    chk("peek_empty_err", 32'(er), 32'h1);
    cmd(1, 1, 1, 8'h5C, rd, er);
    chk("repl_empty_data", 32'(rd), 32'h5C);
    chk("repl_empty_err", 32'(er), 32'h0);
    chk("repl_empty_flag", 32'(o_empty), 32'h2);

    cmd(0, 0, 1, 8'h00, rd, er);
    chk("drain_33", 32'(rd), 32'h33);
    cmd(0, 0, 1, 8'h00, rd, er);
    cmd(0, 0, 1, 8'h00, rd, er);
    chk("drain_11", 32'(rd), 32'h11);
    cmd(0, 1, 0, 8'hA0, rd, er);
    cmd(0, 1, 0, 8'hB0, rd, er);
    cmd(0, 1, 1, 8'hC0, rd, er);
    chk("repl_old_top", 32'(rd), 32'hB0);
    cmd(0, 0, 1, 8'h00, rd, er);
    chk("pop_c0", 32'(rd), 32'hC0);
    cmd(0, 0, 1, 8'h00, rd, er);
    chk("pop_a0", 32'(rd), 32'hA0);
    chk("empty_after", 32'(o_empty), 32'h3);

    cmd(0, 1, 0, 8'h77, rd, er);
    cmd(0, 0, 0, 8'h00, rd, er);
    chk("peek_77", 32'(rd), 32'h77);
    i_rsp_rdy = 1'b0;
    i_cmd_vld = 1'b1; i_cmd_ctx = 1'b1;
    i_cmd_push = 1'b1; i_cmd_pop = 1'b0; i_cmd_data = 8'h99;
    #1 chk("bp_rdy0", 32'(o_cmd_rdy), 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp_rdy", 32'(o_cmd_rdy), 32'h0);
      chk("bp_vld", 32'(o_rsp_vld), 32'h1);
      chk("bp_data", 32'(o_rsp_data), 32'h77);
      chk("bp_ctx", 32'(o_rsp_ctx), 32'h0);
    end
    i_rsp_rdy = 1'b1;
    #1 chk("bp_release_rdy", 32'(o_cmd_rdy), 32'h1);
    @(posedge clk); #1;
    i_cmd_vld = 1'b0;
    chk("bp_next_ctx", 32'(o_rsp_ctx), 32'h1);
    chk("bp_next_err", 32'(o_rsp_err), 32'h0);
    chk("bp_next_empty", 32'(o_empty), 32'h0);

    cmd(0, 1, 0, 8'h01, rd, er);
    cmd(1, 1, 0, 8'h02, rd, er);
    cmd(0, 0, 1, 8'h00, rd, er);
    chk("il_pop0", 32'(rd), 32'h01);
    cmd(1, 0, 1, 8'h00, rd, er);
    chk("il_pop1", 32'(rd), 32'h02);

    for (int i = 0; i < 400; i++) begin
      rnd_drive();
      @(posedge clk); #1;
    end
    i_rsp_rdy = 1'b1;
    cmd(0, 1, 0, 8'h3C, rd, er);
    rnd_drive();
    #2 arst = 1'b1;
    #1;
    chk("arst_vld", 32'(o_rsp_vld), 32'h0);
    chk("arst_empty", 32'(o_empty), 32'h3);
    chk("arst_full", 32'(o_full), 32'h0);
    @(negedge clk); #1 arst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 200; i++) begin
      rnd_drive();
      @(posedge clk); #1;
    end
    i_rsp_rdy = 1'b1;
    i_cmd_vld = 1'b0;
    @(posedge clk); #1;
    cmd(1, 1, 1, 8'h00, rd, er);
    cmd(0, 0, 0, 8'h00, rd, er);
    @(posedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
